bus_slave: RTL and testbench

BUS_SLAVE -- requirements
Module: bus_slave

---
 rtl/async_proto_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/bus_slave.sv | 162 ++++++++++++++++
 tb/tb_bus_slave.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/async_proto_pkg.sv
// Shared definitions for the four-phase asynchronous bus master and slave:
// FSM state encoding and default bus/storage dimensions.
package async_proto_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_CAP   = 2'd1,
      RD_DRV   = 2'd2,
      ACK_WAIT = 2'd3
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Shift the asynchronous input through two flops to resolve metastability
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/bus_slave.sv
// Four-phase handshake bus slave backed by a small FIFO. Writes push the bus
// word into the tail, reads return the head word and pop it. ack and the bus
// drive enable come straight from flops.
module bus_slave
   import async_proto_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   input  logic                   rw,
   inout  wire  [WIDTH-1:0]       data_bus,
   output logic                   ack,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   logic              req_s;
   logic              push_s;

   state_t            state_q, state_d;
   logic              ack_q, ack_d;
   logic              drv_q, drv_d;
   logic [WIDTH-1:0]  rd_data_q, rd_data_d;
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];

   sync_2ff u_req_sync (
      .clk (clk),
      .rst (rst),
      .d   (req),
      .q   (req_s)
   );

   // Next-state, FIFO bookkeeping and registered-output values for the handshake
   always_comb begin
      state_d   = state_q;
      ack_d     = ack_q;
      drv_d     = drv_q;
      rd_data_d = rd_data_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      push_s    = 1'b0;

      case (state_q)
         IDLE: begin
            ack_d = 1'b0;
            drv_d = 1'b0;
            if (req_s) begin
               if (rw) begin
                  // Start driving the head word (or zero when empty) as RD_DRV begins
                  state_d   = RD_DRV;
                  drv_d     = 1'b1;
                  if (count_q != CNT_ZERO) begin
                     rd_data_d = mem_q[head_q];
                  end else begin
                     rd_data_d = {WIDTH{1'b0}};
                  end
               end else begin
                  state_d = WR_CAP;
               end
            end else begin
               state_d = IDLE;
            end
         end

         WR_CAP: begin
            state_d = ACK_WAIT;
            ack_d   = 1'b1;
            if (count_q < CNT_FULL) begin
               push_s  = 1'b1;
               tail_d  = tail_q + PW'(1);
               count_d = count_q + CW'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end

         RD_DRV: begin
            state_d = ACK_WAIT;
            ack_d   = 1'b1;
            if (count_q != CNT_ZERO) begin
               head_d  = head_q + PW'(1);
               count_d = count_q - CW'(1);
            end else begin
               unf_d = 1'b1;
            end
         end

         ACK_WAIT: begin
            // Hold ack (and any read data) until the master drops req
            if (!req_s) begin
               state_d = IDLE;
               ack_d   = 1'b0;
               drv_d   = 1'b0;
            end else begin
               state_d = ACK_WAIT;
            end
         end

         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
            drv_d   = 1'b0;
         end
      endcase
   end

   // Handshake FSM and FIFO control registers; reset aborts any transfer in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         drv_q     <= 1'b0;
         rd_data_q <= {WIDTH{1'b0}};
         head_q    <= {PW{1'b0}};
         tail_q    <= {PW{1'b0}};
         count_q   <= CNT_ZERO;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         drv_q     <= drv_d;
         rd_data_q <= rd_data_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // FIFO storage write port; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         mem_q[tail_q] <= data_bus;
      end
   end

   assign data_bus  = drv_q ? rd_data_q : {WIDTH{1'bz}};
   assign ack       = ack_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_bus_slave.sv
// Directed testbench for bus_slave. The bus carries pull-ups, so a released
// bus reads back as all ones; read data values in this bench avoid 4'hF.
module tb_bus_slave;

   logic       clk;
   logic       rst;
   logic       req;
   logic       rw;
   logic       ack;
   logic [2:0] count;
   logic       overflow;
   logic       underflow;
   logic       tb_drv;
   logic [3:0] tb_data;
   wire  [3:0] data_bus;

   int tests_run;
   int tests_failed;

   assign data_bus = tb_drv ? tb_data : 4'bzzzz;
   pullup (data_bus[0]);
   pullup (data_bus[1]);
   pullup (data_bus[2]);
   pullup (data_bus[3]);

   bus_slave #(.WIDTH(4), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .rw        (rw),
      .data_bus  (data_bus),
      .ack       (ack),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One complete four-phase transfer; returns bus value seen at ack and edge counts (0 = timeout)
   task automatic xfer(input logic is_rd, input logic [3:0] wdata,
                       output logic [3:0] bus_at_ack, output int rise_n, output int fall_n);
      rise_n = 0;
      fall_n = 0;
      @(negedge clk);
      rw      = is_rd;
      tb_data = wdata;
      tb_drv  = ~is_rd;
      req     = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) begin
            rise_n = i;
            break;
         end
      end
      tb_drv = 1'b0;
      #1 bus_at_ack = data_bus;
      @(negedge clk);
      req = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b0) begin
            fall_n = i;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst    = 1'b1;
      req    = 1'b0;
      tb_drv = 1'b0;
      @(negedge clk);
      rst    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; rw = 1'b0; tb_drv = 1'b0; tb_data = 4'h0;
      repeat (2) @(negedge clk);
      tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b want 0", ack); end
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
      tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_unf: got %b want 0", underflow); end
      tests_run++; if (data_bus !== 4'hF) begin tests_failed++; $display("FAIL reset_bus: got %h want released(F)", data_bus); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write_basic();
      logic [3:0] b;
      int r, f;
      apply_reset();
      xfer(1'b0, 4'hF, b, r, f);
      tests_run++; if (r !== 4) begin tests_failed++; $display("FAIL wr_ack_rise: got edge %0d want 4", r); end
      tests_run++; if (f !== 3) begin tests_failed++; $display("FAIL wr_ack_fall: got edge %0d want 3", f); end
      tests_run++; if (b !== 4'hF) begin tests_failed++; $display("FAIL wr_bus_ack: got %h want released(F)", b); end
      tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL wr_count: got %0d want 1", count); end
      tests_run++; if (data_bus !== 4'hF) begin tests_failed++; $display("FAIL wr_bus_idle: got %h want released(F)", data_bus); end
   endtask

   task automatic test_write_read();
      logic [3:0] b;
      int r, f;
      apply_reset();
      xfer(1'b0, 4'hA, b, r, f);
      xfer(1'b0, 4'h5, b, r, f);
      tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL wr2_count: got %0d want 2", count); end
      xfer(1'b1, 4'h0, b, r, f);
      tests_run++; if (b !== 4'hA) begin tests_failed++; $display("FAIL rd1_data: got %h want a", b); end
      tests_run++; if (r !== 4) begin tests_failed++; $display("FAIL rd1_rise: got edge %0d want 4", r); end
      tests_run++; if (data_bus !== 4'hF) begin tests_failed++; $display("FAIL rd1_release: got %h want released(F)", data_bus); end
      xfer(1'b1, 4'h0, b, r, f);
      tests_run++; if (b !== 4'h5) begin tests_failed++; $display("FAIL rd2_data: got %h want 5", b); end
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL rd2_count: got %0d want 0", count); end
      tests_run++; if ({overflow, underflow} !== 2'b00) begin tests_failed++; $display("FAIL wr_rd_flags: got %b want 00", {overflow, underflow}); end
   endtask

   task automatic test_overflow();
      logic [3:0] b;
      int r, f;
      apply_reset();
      for (int i = 1; i <= 4; i++) xfer(1'b0, 4'(i), b, r, f);
      tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL full_count: got %0d want 4", count); end
      tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL full_ovf: got %b want 0", overflow); end
      xfer(1'b0, 4'h5, b, r, f);
      tests_run++; if (r !== 4) begin tests_failed++; $display("FAIL ovf_rise: got edge %0d want 4", r); end
      tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d want 4", count); end
      for (int i = 1; i <= 4; i++) begin
         xfer(1'b1, 4'h0, b, r, f);
         tests_run++; if (b !== 4'(i)) begin tests_failed++; $display("FAIL ovf_rd%0d: got %h want %h", i, b, 4'(i)); end
      end
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL ovf_drain_count: got %0d want 0", count); end
      tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_unf: got %b want 0", underflow); end
   endtask

   task automatic test_underflow();
      logic [3:0] b;
      int r, f;
      apply_reset();
      xfer(1'b1, 4'h0, b, r, f);
      tests_run++; if (b !== 4'h0) begin tests_failed++; $display("FAIL unf_data: got %h want 0", b); end
      tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL unf_flag: got %b want 1", underflow); end
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL unf_count: got %0d want 0", count); end
      xfer(1'b0, 4'h7, b, r, f);
      xfer(1'b1, 4'h0, b, r, f);
      tests_run++; if (b !== 4'h7) begin tests_failed++; $display("FAIL unf_after_rd: got %h want 7", b); end
      tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL unf_sticky: got %b want 1", underflow); end
   endtask

   task automatic test_reset_mid_read();
      logic [3:0] b;
      int r, f, got;
      apply_reset();
      xfer(1'b0, 4'h9, b, r, f);
      xfer(1'b0, 4'h8, b, r, f);
      @(negedge clk);
      rw  = 1'b1;
      req = 1'b1;
      got = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) begin got = i; break; end
      end
      tests_run++; if (got !== 4) begin tests_failed++; $display("FAIL mid_rise: got edge %0d want 4", got); end
      #1;
      tests_run++; if (data_bus !== 4'h9) begin tests_failed++; $display("FAIL mid_bus: got %h want 9", data_bus); end
      tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL mid_count: got %0d want 1", count); end
      #1 rst = 1'b1;
      #1;
      tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL arst_ack: got %b want 0", ack); end
      tests_run++; if (data_bus !== 4'hF) begin tests_failed++; $display("FAIL arst_bus: got %h want released(F)", data_bus); end
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL arst_count: got %0d want 0", count); end
      // req stays high through reset release and must start a fresh read of an empty FIFO
      @(negedge clk);
      rst = 1'b0;
      got = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) begin got = i; break; end
      end
      #1;
      tests_run++; if (got !== 4) begin tests_failed++; $display("FAIL rearm_rise: got edge %0d want 4", got); end
      tests_run++; if (data_bus !== 4'h0) begin tests_failed++; $display("FAIL rearm_bus: got %h want 0", data_bus); end
      tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL rearm_unf: got %b want 1", underflow); end
      @(negedge clk);
      req = 1'b0;
      got = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b0) begin got = i; break; end
      end
      tests_run++; if (got !== 3) begin tests_failed++; $display("FAIL rearm_fall: got edge %0d want 3", got); end
   endtask

   task automatic test_short_req();
      logic [3:0] b;
      int r, f, high;
      apply_reset();
      @(negedge clk);
      rw      = 1'b0;
      tb_data = 4'h6;
      tb_drv  = 1'b1;
      req     = 1'b1;
      @(negedge clk);
      req  = 1'b0;
      high = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) begin high++; tb_drv = 1'b0; end
      end
      tb_drv = 1'b0;
      tests_run++; if (high !== 1) begin tests_failed++; $display("FAIL short_ack_len: got %0d cycles want 1", high); end
      tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL short_count: got %0d want 1", count); end
      xfer(1'b1, 4'h0, b, r, f);
      tests_run++; if (r !== 4) begin tests_failed++; $display("FAIL short_next_rise: got edge %0d want 4", r); end
      tests_run++; if (b !== 4'h6) begin tests_failed++; $display("FAIL short_next_data: got %h want 6", b); end
   endtask

   task automatic test_wrap();
      logic [3:0] b;
      logic [3:0] v;
      int r, f;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         v = 4'(i * 3 + 1);
         xfer(1'b0, v, b, r, f);
         xfer(1'b1, 4'h0, b, r, f);
         tests_run++; if (b !== v) begin tests_failed++; $display("FAIL wrap_rd%0d: got %h want %h", i, b, v); end
         tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL wrap_count%0d: got %0d want 0", i, count); end
      end
      tests_run++; if ({overflow, underflow} !== 2'b00) begin tests_failed++; $display("FAIL wrap_flags: got %b want 00", {overflow, underflow}); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_write_basic();
      test_write_read();
      test_overflow();
      test_underflow();
      test_reset_mid_read();
      test_short_req();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
